write_ptr_ctrl: RTL

Write-domain pointer controller for the asynchronous FIFO, sitting directly upstream of full_flag_logic.
- Owns the binary write pointer and generates the memory write strobe and address.
- Produces the registered Gray write pointer that crosses into the read domain.
- Synchronises the read domain's Gray pointer into write_clk; that pointer feeds full_flag_logic.
- Consumes full back from full_flag_logic to block writes. It also reports occupancy, almost_full and a sticky overflow error.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/gray_decoder.sv | 16 +
 rtl/write_ptr_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions used by both the write- and read-side pointer controllers.
package fifo_pkg;

  localparam int ADDR_W_DEF      = 4;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Binary to Gray, full 32-bit width; callers slice to their pointer width.
  function automatic logic [31:0] gray_enc(input logic [31:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic logic [31:0] gray_dec(input logic [31:0] gray);
    logic [31:0] bin;
    bin = gray;
    for (int s = 1; s < 32; s++) bin = bin ^ (gray >> s);
    return bin;
  endfunction

endpackage

// File: rtl/gray_decoder.sv
// Combinational Gray-to-binary decoder of parameterized width.
module gray_decoder #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  // MSB passes straight through; each lower bit folds in the decoded bit above it.
  always_comb begin
    bin_o = '0;
    bin_o[W-1] = gray_i[W-1];
    for (int i = W - 2; i >= 0; i--) bin_o[i] = bin_o[i+1] ^ gray_i[i];
  end

endmodule

// File: rtl/write_ptr_ctrl.sv
// Write-domain pointer controller: binary/Gray write pointer, read-pointer
// synchroniser, write strobe, pessimistic occupancy, almost_full and sticky overflow.
module write_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int AF_THRESH   = 12
) (
  input  logic              write_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic              full,
  input  logic [ADDR_W-1:0] read_ptr_gray,
  output logic [ADDR_W-1:0] write_ptr,
  output logic [ADDR_W-1:0] write_ptr_gray,
  output logic [ADDR_W-1:0] synch_read_ptr,
  output logic              mem_we,
  output logic [ADDR_W-1:0] write_count,
  output logic              almost_full,
  output logic              overflow
);

  // Elaboration-time parameter legality.
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("write_ptr_ctrl: SYNC_STAGES out of range 2..4");
  end
  if (AF_THRESH < 1 || AF_THRESH > (2 ** ADDR_W) - 1) begin : g_bad_af
    $error("write_ptr_ctrl: AF_THRESH out of range 1..2^ADDR_W-1");
  end

  logic [SYNC_STAGES-1:0][ADDR_W-1:0] sync_q, sync_d;
  logic [ADDR_W-1:0] wp_q, wp_d;
  logic [ADDR_W-1:0] wpg_q, wpg_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              af_q, af_d;
  logic              ovf_q, ovf_d;
  logic [ADDR_W-1:0] rd_bin;

  // Strobe is gated by reset so a write coinciding with reset never reaches memory.
  assign mem_we = wr_en & ~full & rst_n;

  gray_decoder #(.W(ADDR_W)) u_rd_dec (
    .gray_i (sync_q[SYNC_STAGES-1]),
    .bin_o  (rd_bin)
  );

  // Next-state: plain shift for the synchroniser, pointer advance on accept,
  // occupancy from the pointer being registered this edge against the synced read pointer.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], read_ptr_gray};
    wp_d   = wp_q + ADDR_W'(mem_we);
    wpg_d  = wp_d ^ (wp_d >> 1);
    cnt_d  = wp_d - rd_bin;
    af_d   = (cnt_d >= ADDR_W'(AF_THRESH));
    ovf_d  = ovf_q | (wr_en & full);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge write_clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      wp_q   <= '0;
      wpg_q  <= '0;
      cnt_q  <= '0;
      af_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      wp_q   <= wp_d;
      wpg_q  <= wpg_d;
      cnt_q  <= cnt_d;
      af_q   <= af_d;
      ovf_q  <= ovf_d;
    end
  end

  assign write_ptr      = wp_q;
  assign write_ptr_gray = wpg_q;
  assign synch_read_ptr = sync_q[SYNC_STAGES-1];
  assign write_count    = cnt_q;
  assign almost_full    = af_q;
  assign overflow       = ovf_q;

endmodule
